// File: rtl/input_conditioner.sv
// Raw switch/button conditioner: per-channel two-flop synchroniser, polarity
// normalisation, debounce, and registered rise/fall/long-press pulses.
// One lane module per channel; the top only fans raw_in out to the lanes.

module input_conditioner_lane #(
   parameter logic ACTIVE_LOW      = 1'b0,
   parameter int   DEBOUNCE_CYCLES = 250000,
   parameter int   HOLD_CYCLES     = 25000000
) (
   input  logic vga_clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);

   logic          s1, s2;
   logic          n;
   logic          flip;
   logic          level_next;
   logic          held;
   logic [DW-1:0] dcnt;
   logic [HW-1:0] hcnt;

   // n is the pressed/on view of the pin; flip marks the terminal mismatch cycle
   assign n          = s2 ^ ACTIVE_LOW;
   assign flip       = (n != level) && (dcnt == D_LAST);
   assign level_next = flip ? n : level;
   // held: level is 1 now and stays 1 across this edge, so a release on the
   // same edge as the terminal hold count suppresses long_press
   assign held       = level & level_next;

   // two-flop synchroniser, reset to the idle (unpressed) pin level
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         s1 <= ACTIVE_LOW;
         s2 <= ACTIVE_LOW;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // debounce: any matching cycle restarts the mismatch run
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         dcnt  <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         level <= level_next;
         rise  <= flip & n;
         fall  <= flip & ~n;
         if ((n == level) || flip) dcnt <= '0;
         else                      dcnt <= dcnt + DW'(1);
      end
   end

   // hold timer: counts from the rise cycle, saturates, fires once per press
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         hcnt       <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= held && (hcnt == H_LAST);
         if (!held)              hcnt <= '0;
         else if (hcnt != H_MAX) hcnt <= hcnt + HW'(1);
      end
   end
endmodule

module input_conditioner #(
   parameter int                    NUM_INPUTS      = 4,
   parameter logic [NUM_INPUTS-1:0] ACTIVE_LOW_MASK = 4'b1100,
   parameter int                    DEBOUNCE_CYCLES = 250000,
   parameter int                    HOLD_CYCLES     = 25000000
) (
   input  logic                  vga_clock,
   input  logic                  reset,
   input  logic [NUM_INPUTS-1:0] raw_in,
   output logic [NUM_INPUTS-1:0] level_out,
   output logic [NUM_INPUTS-1:0] rise_pulse,
   output logic [NUM_INPUTS-1:0] fall_pulse,
   output logic [NUM_INPUTS-1:0] long_press
);
   // independent identical lanes, one per raw input
   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
      input_conditioner_lane #(
         .ACTIVE_LOW      (ACTIVE_LOW_MASK[g]),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES)
      ) u_lane (
         .vga_clock  (vga_clock),
         .reset      (reset),
         .raw        (raw_in[g]),
         .level      (level_out[g]),
         .rise       (rise_pulse[g]),
         .fall       (fall_pulse[g]),
         .long_press (long_press[g])
      );
   end
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed vector table, hand-written corner
// sequences and random stimulus, all against a history-based reference model.

module tb_input_conditioner;
   localparam int          N    = 4;
   localparam int          DEB  = 4;
   localparam int          HOLD = 10;
   localparam logic [3:0]  MASK = 4'b1100;

   logic       vga_clock = 1'b0;
   logic       reset;
   logic [3:0] raw_in;
   logic [3:0] level_out, rise_pulse, fall_pulse, long_press;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   input_conditioner #(
      .NUM_INPUTS      (N),
      .ACTIVE_LOW_MASK (MASK),
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD)
   ) dut (
      .vga_clock  (vga_clock),
      .reset      (reset),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .long_press (long_press)
   );

   always #5 vga_clock = ~vga_clock;

   // reference model: synchroniser delay line, window of recent normalised
   // samples, and length of the current pressed run
   logic [3:0] m_s1, m_s2, m_level, m_rise, m_fall, m_lp;
   int         m_run [N];
   bit         hist  [N][$];

   typedef struct {
      logic [3:0] raw;
      logic       rst;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] lp;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // advance the model across one edge using the inputs now applied
   task automatic model_step();
      if (reset) begin
         m_s1 = MASK; m_s2 = MASK;
         m_level = '0; m_rise = '0; m_fall = '0; m_lp = '0;
         for (int c = 0; c < N; c++) begin
            hist[c].delete();
            m_run[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            bit n, all_diff, newl;
            n = m_s2[c] ^ MASK[c];
            hist[c].push_back(n);
            if (hist[c].size() > DEB) void'(hist[c].pop_front());
            all_diff = (hist[c].size() == DEB);
            foreach (hist[c][k]) if (hist[c][k] == m_level[c]) all_diff = 0;
            newl      = all_diff ? ~m_level[c] : m_level[c];
            m_rise[c] = newl & ~m_level[c];
            m_fall[c] = ~newl & m_level[c];
            m_run[c]  = newl ? m_run[c] + 1 : 0;
            m_lp[c]   = newl && (m_run[c] == HOLD + 1);
            m_level[c] = newl;
         end
         m_s2 = m_s1;
         m_s1 = raw_in;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge vga_clock);
      #1;
      cyc++;
      chk("model_level", level_out,  m_level);
      chk("model_rise",  rise_pulse, m_rise);
      chk("model_fall",  fall_pulse, m_fall);
      chk("model_long",  long_press, m_lp);
   endtask

   // ticks until the selected pulse shows on channel ch; -1 if never
   task automatic wait_for(input int sel, input int ch, input int max, output int n);
      logic [3:0] v;
      n = -1;
      for (int k = 1; k <= max; k++) begin
         tick();
         case (sel)
            0:       v = rise_pulse;
            1:       v = fall_pulse;
            default: v = long_press;
         endcase
         if (v[ch]) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      vec_t v;
      int   n, cnt, first;

      // vector table: reset, 20 idle cycles, then a press on channel 2
      for (int k = 0; k < 2; k++) begin
         v = '{raw: 4'b1100, rst: 1'b1, lvl: 4'b0, rise: 4'b0, fall: 4'b0, lp: 4'b0};
         vecs.push_back(v);
      end
      for (int k = 0; k < 20; k++) begin
         v = '{raw: 4'b1100, rst: 1'b0, lvl: 4'b0, rise: 4'b0, fall: 4'b0, lp: 4'b0};
         vecs.push_back(v);
      end
      for (int k = 0; k < 17; k++) begin
         v.raw  = 4'b1000;
         v.rst  = 1'b0;
         v.lvl  = (k >= 5)  ? 4'b0100 : 4'b0000;
         v.rise = (k == 5)  ? 4'b0100 : 4'b0000;
         v.fall = 4'b0000;
         v.lp   = (k == 15) ? 4'b0100 : 4'b0000;
         vecs.push_back(v);
      end

      raw_in = 4'b1100;
      reset  = 1'b1;
      foreach (vecs[i]) begin
         raw_in = vecs[i].raw;
         reset  = vecs[i].rst;
         tick();
         chk("tbl_level", level_out,  vecs[i].lvl);
         chk("tbl_rise",  rise_pulse, vecs[i].rise);
         chk("tbl_fall",  fall_pulse, vecs[i].fall);
         chk("tbl_long",  long_press, vecs[i].lp);
      end

      // bounce on channel 0 must never reach level_out
      for (int r = 0; r < 4; r++) begin
         raw_in[0] = (r % 2 == 0);
         repeat (3) begin
            tick();
            chki("bounce_level0", int'(level_out[0]), 0);
         end
      end
      raw_in[0] = 1'b1;
      wait_for(0, 0, 20, n);
      chki("bounce_rise_latency", n, 6);
      cnt = 0;
      repeat (12) begin tick(); if (rise_pulse[0]) cnt++; end
      chki("bounce_single_rise", cnt, 0);

      // long press on channel 3
      raw_in[3] = 1'b0;
      wait_for(0, 3, 20, n);
      chki("long_rise_latency", n, 6);
      cnt = 0; first = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (long_press[3]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      chki("long_count", cnt, 1);
      chki("long_delay", first, HOLD);
      raw_in[3] = 1'b1;
      wait_for(1, 3, 20, n);
      chki("long_fall_latency", n, 6);
      cnt = 0;
      repeat (10) begin tick(); if (fall_pulse[3]) cnt++; end
      chki("long_single_fall", cnt, 0);

      // release landing on the edge the hold count would complete
      raw_in[1] = 1'b1;
      wait_for(0, 1, 20, n);
      chki("relwin_rise_latency", n, 6);
      repeat (4) tick();
      raw_in[1] = 1'b0;
      cnt = 0; n = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (long_press[1]) cnt++;
         if (fall_pulse[1] && n < 0) n = k;
      end
      chki("relwin_fall_latency", n, 6);
      chki("relwin_no_long", cnt, 0);

      // reset while channel 2 is held: it becomes a fresh press
      repeat (20) tick();
      reset = 1'b1;
      repeat (3) begin
         tick();
         chk("rst_level", level_out, 4'b0);
         chk("rst_rise",  rise_pulse, 4'b0);
         chk("rst_fall",  fall_pulse, 4'b0);
         chk("rst_long",  long_press, 4'b0);
      end
      reset = 1'b0;
      wait_for(0, 2, 20, n);
      chki("rst_repress_latency", n, 6);

      // simultaneous press on channels 0 and 2
      raw_in = 4'b1100;
      repeat (12) tick();
      raw_in = 4'b1001;
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (rise_pulse != 4'b0) begin
            n = k;
            break;
         end
      end
      chki("simul_latency", n, 6);
      chk("simul_rise", rise_pulse, 4'b0101);

      // random stimulus against the model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 5) == 0) begin
            int idx;
            idx = $urandom_range(0, N - 1);
            raw_in[idx] = ~raw_in[idx];
         end
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
